frame_sync_lock: RTL and testbench

Frame-alignment stage that sits directly downstream of the serial 1011 marker detector. It consumes the detector's one-cycle match pulse (one serial bit per clk) and acquires frame lock when markers recur exactly FRAME_LEN cycles apart. Once locked, it tracks the frame position, flywheels through isolated missing markers and drops lock after MISS_N consecutive misses. Its outputs give the frame boundary and bit position to the downstream deframer.

---
 rtl/frame_sync_lock.sv | 137 +++++++++++++
 tb/tb_frame_sync_lock.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_lock.sv
// Frame-alignment FSM after the 1011 marker detector: hunts, verifies, locks and flywheels on markers.
// Optional SYNC_STATS_EN adds an 8-bit saturating sync_err counter on err_cnt.
//
// state  | meaning
// HUNT   | no alignment; waiting for any marker, pos held at 0
// VERIFY | candidate alignment; counting correctly spaced markers
// LOCK   | aligned; marker seen in the last expected slot
// COAST  | aligned but flywheeling through missed marker slots
module frame_sync_lock #(
    parameter int FRAME_LEN = 16,
    parameter int POS_W     = 5,
    parameter int VERIFY_N  = 2,
    parameter int MISS_N    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    output logic             locked,
    output logic             frame_start,
    output logic [POS_W-1:0] bit_pos,
`ifdef SYNC_STATS_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             sync_err
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2,
        COAST  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [POS_W-1:0] pos, pos_nxt, pos_inc;
    logic [2:0]       vcnt, vcnt_nxt;
    logic [2:0]       miss, miss_nxt;
    logic             serr_nxt;
    logic             slot;

    assign slot    = (pos == '0);
    assign pos_inc = (pos == POS_W'(FRAME_LEN - 1)) ? '0 : pos + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= HUNT;
            pos      <= '0;
            vcnt     <= '0;
            miss     <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            vcnt     <= vcnt_nxt;
            miss     <= miss_nxt;
            sync_err <= serr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos_inc;
        vcnt_nxt  = vcnt;
        miss_nxt  = miss;
        serr_nxt  = 1'b0;
        case (state)
            HUNT: begin
                pos_nxt = '0;
                if (det) begin
                    // the det cycle itself is position 0
                    state_nxt = VERIFY;
                    pos_nxt   = POS_W'(1);
                    vcnt_nxt  = '0;
                end
            end
            VERIFY: begin
                if (slot) begin
                    if (!det) begin
                        state_nxt = HUNT;
                        pos_nxt   = '0;
                    end else if (vcnt == 3'(VERIFY_N - 1)) begin
                        state_nxt = LOCK;
                        miss_nxt  = '0;
                    end else begin
                        vcnt_nxt = vcnt + 3'd1;
                    end
                end
            end
            LOCK: begin
                if (slot && !det) begin
                    serr_nxt = 1'b1;
                    if (MISS_N == 1) begin
                        state_nxt = HUNT;
                        pos_nxt   = '0;
                    end else begin
                        state_nxt = COAST;
                        miss_nxt  = 3'd1;
                    end
                end
            end
            COAST: begin
                if (slot) begin
                    if (det) begin
                        state_nxt = LOCK;
                        miss_nxt  = '0;
                    end else if (miss == 3'(MISS_N - 1)) begin
                        state_nxt = HUNT;
                        pos_nxt   = '0;
                        serr_nxt  = 1'b1;
                    end else begin
                        miss_nxt = miss + 3'd1;
                        serr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                pos_nxt   = '0;
            end
        endcase
    end

    assign locked      = (state == LOCK) || (state == COAST);
    assign frame_start = locked && slot;
    assign bit_pos     = pos;

`ifdef SYNC_STATS_EN
    // counts pulses as they are issued, so err_cnt moves in step with sync_err
    always_ff @(posedge clk) begin
        if (!rst)
            err_cnt <= '0;
        else if (serr_nxt && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_frame_sync_lock.sv
// Directed bench for frame_sync_lock at default parameters; cycle 0 is the first cycle after reset release.
// Build with +define+SYNC_STATS_EN to also check err_cnt.
module tb_frame_sync_lock;

    logic       clk;
    logic       rst;
    logic       det;
    logic       locked;
    logic       frame_start;
    logic [4:0] bit_pos;
    logic       sync_err;
`ifdef SYNC_STATS_EN
    logic [7:0] err_cnt;
`endif

    int nvec;
    int nerr;

    frame_sync_lock #(
        .FRAME_LEN(16),
        .POS_W    (5),
        .VERIFY_N (2),
        .MISS_N   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .det        (det),
        .locked     (locked),
        .frame_start(frame_start),
        .bit_pos    (bit_pos),
`ifdef SYNC_STATS_EN
        .err_cnt    (err_cnt),
`endif
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b0;
        det = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        det = 1'b1;
        tick();
        tick();
        nvec++;
        if (locked !== 1'b0 || frame_start !== 1'b0 || bit_pos !== 5'd0 || sync_err !== 1'b0) begin
            nerr++;
            $display("FAIL reset: locked=%b fs=%b pos=%0d serr=%b, want all 0",
                     locked, frame_start, bit_pos, sync_err);
        end
`ifdef SYNC_STATS_EN
        nvec++;
        if (err_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
`endif
        rst = 1'b1;
        det = 1'b0;
    endtask

    // markers at 10, 26, 42, ... ; lock from 43, frame_start at 58, 74, ...
    task automatic test_acquire();
        logic       e_lock, e_fs;
        logic [4:0] e_pos;
        restart();
        for (int c = 0; c <= 100; c++) begin
            e_lock = (c >= 43);
            e_pos  = (c <= 10) ? 5'd0 : 5'((c - 10) % 16);
            e_fs   = e_lock && (e_pos == 5'd0);
            nvec++;
            if (locked !== e_lock || frame_start !== e_fs || bit_pos !== e_pos || sync_err !== 1'b0) begin
                nerr++;
                $display("FAIL acquire c=%0d: locked=%b fs=%b pos=%0d serr=%b, want %b %b %0d 0",
                         c, locked, frame_start, bit_pos, sync_err, e_lock, e_fs, e_pos);
            end
            det = (c >= 10) && ((c - 10) % 16 == 0);
            tick();
        end
    endtask

    task automatic test_verify_fail();
        logic [4:0] e_pos;
        restart();
        for (int c = 0; c <= 70; c++) begin
            e_pos = (c <= 10 || c >= 43) ? 5'd0 : 5'((c - 10) % 16);
            nvec++;
            if (locked !== 1'b0 || frame_start !== 1'b0 || bit_pos !== e_pos || sync_err !== 1'b0) begin
                nerr++;
                $display("FAIL verify_fail c=%0d: locked=%b fs=%b pos=%0d serr=%b, want 0 0 %0d 0",
                         c, locked, frame_start, bit_pos, sync_err, e_pos);
            end
            det = (c == 10) || (c == 26);
            tick();
        end
    endtask

    task automatic test_flywheel();
        logic       e_lock, e_fs, e_serr;
        logic [4:0] e_pos;
        restart();
        for (int c = 0; c <= 120; c++) begin
            e_lock = (c >= 43);
            e_pos  = (c <= 10) ? 5'd0 : 5'((c - 10) % 16);
            e_fs   = e_lock && (e_pos == 5'd0);
            e_serr = (c == 75);
            nvec++;
            if (locked !== e_lock || frame_start !== e_fs || bit_pos !== e_pos || sync_err !== e_serr) begin
                nerr++;
                $display("FAIL flywheel c=%0d: locked=%b fs=%b pos=%0d serr=%b, want %b %b %0d %b",
                         c, locked, frame_start, bit_pos, sync_err, e_lock, e_fs, e_pos, e_serr);
            end
`ifdef SYNC_STATS_EN
            nvec++;
            if (err_cnt !== ((c >= 75) ? 8'd1 : 8'd0)) begin
                nerr++;
                $display("FAIL flywheel_err_cnt c=%0d: got %0d", c, err_cnt);
            end
`endif
            det = (c >= 10) && ((c - 10) % 16 == 0) && (c != 74);
            tick();
        end
    endtask

    // last good slot 58; misses at 74, 90, 106
    task automatic test_loss();
        logic       e_lock, e_fs, e_serr;
        logic [4:0] e_pos;
        logic [7:0] e_cnt;
        restart();
        for (int c = 0; c <= 130; c++) begin
            e_lock = (c >= 43) && (c < 107);
            e_pos  = (c <= 10 || c >= 107) ? 5'd0 : 5'((c - 10) % 16);
            e_fs   = e_lock && (e_pos == 5'd0);
            e_serr = (c == 75) || (c == 91) || (c == 107);
            e_cnt  = (c >= 107) ? 8'd3 : (c >= 91) ? 8'd2 : (c >= 75) ? 8'd1 : 8'd0;
            nvec++;
            if (locked !== e_lock || frame_start !== e_fs || bit_pos !== e_pos || sync_err !== e_serr) begin
                nerr++;
                $display("FAIL loss c=%0d: locked=%b fs=%b pos=%0d serr=%b, want %b %b %0d %b",
                         c, locked, frame_start, bit_pos, sync_err, e_lock, e_fs, e_pos, e_serr);
            end
`ifdef SYNC_STATS_EN
            nvec++;
            if (err_cnt !== e_cnt) begin
                nerr++;
                $display("FAIL loss_err_cnt c=%0d: got %0d want %0d", c, err_cnt, e_cnt);
            end
`endif
            det = (c >= 10) && (c <= 58) && ((c - 10) % 16 == 0);
            tick();
        end
    endtask

    task automatic test_spurious();
        logic       e_lock, e_fs;
        logic [4:0] e_pos;
        int         ph;
        restart();
        for (int c = 0; c <= 120; c++) begin
            e_lock = (c >= 43);
            e_pos  = (c <= 10) ? 5'd0 : 5'((c - 10) % 16);
            e_fs   = e_lock && (e_pos == 5'd0);
            nvec++;
            if (locked !== e_lock || frame_start !== e_fs || bit_pos !== e_pos || sync_err !== 1'b0) begin
                nerr++;
                $display("FAIL spurious c=%0d: locked=%b fs=%b pos=%0d serr=%b, want %b %b %0d 0",
                         c, locked, frame_start, bit_pos, sync_err, e_lock, e_fs, e_pos);
            end
            ph  = (c - 10) % 16;
            det = (c >= 10) && ((ph == 0) || (c > 10 && (ph == 5 || ph == 9)));
            tick();
        end
    endtask

    // rst low for the edge of cycle 80, then reacquire from a marker at 85
    task automatic test_reset_mid_lock();
        logic       e_lock, e_fs;
        logic [4:0] e_pos;
        restart();
        for (int c = 0; c <= 140; c++) begin
            if (c <= 80) begin
                e_lock = (c >= 43);
                e_pos  = (c <= 10) ? 5'd0 : 5'((c - 10) % 16);
            end else begin
                e_lock = (c >= 118);
                e_pos  = (c <= 85) ? 5'd0 : 5'((c - 85) % 16);
            end
            e_fs = e_lock && (e_pos == 5'd0);
            nvec++;
            if (locked !== e_lock || frame_start !== e_fs || bit_pos !== e_pos || sync_err !== 1'b0) begin
                nerr++;
                $display("FAIL reset_mid_lock c=%0d: locked=%b fs=%b pos=%0d serr=%b, want %b %b %0d 0",
                         c, locked, frame_start, bit_pos, sync_err, e_lock, e_fs, e_pos);
            end
`ifdef SYNC_STATS_EN
            nvec++;
            if (err_cnt !== 8'd0) begin
                nerr++;
                $display("FAIL reset_mid_lock_err_cnt c=%0d: got %0d want 0", c, err_cnt);
            end
`endif
            if (c < 80)
                det = (c >= 10) && ((c - 10) % 16 == 0);
            else
                det = (c >= 85) && ((c - 85) % 16 == 0);
            rst = (c != 80);
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b0;
        det  = 1'b0;
        test_reset();
        test_acquire();
        test_verify_fail();
        test_flywheel();
        test_loss();
        test_spurious();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
